// File: rtl/spc_stack_if.sv
// Control/data bundle for the subroutine PC stack: request and push-data inputs,
// top-of-stack word, pointer and sticky error flags.
interface spc_stack_if;
  logic        state_fetch;
  logic        spcpush;
  logic        spcpop;
  logic        destspc;
  logic [13:0] wpc;
  logic [18:0] l;
  logic        spc_clr_err;
  logic [18:0] spc;
  logic [4:0]  spcptr;
  logic        spco;
  logic        spcu;

  modport master (
    output state_fetch, spcpush, spcpop, destspc, wpc, l, spc_clr_err,
    input  spc, spcptr, spco, spcu
  );

  modport slave (
    input  state_fetch, spcpush, spcpop, destspc, wpc, l, spc_clr_err,
    output spc, spcptr, spco, spcu
  );
endinterface

// File: rtl/spc_stack.sv
// 32 x 19-bit subroutine PC stack with a combinational top-of-stack read.
// Define SPC_GUARD_EN to add a depth counter with sticky overflow/underflow protection.
module spc_stack (
  input logic        clk,
  input logic        reset,
  spc_stack_if.slave bus
);
  localparam int unsigned Depth = 32;
  localparam int unsigned Width = 19;
  localparam int unsigned PtrW  = 5;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [Width-1:0] spcw;
  logic             wr_en;
  logic [PtrW-1:0]  wr_idx;
  logic             push_only, pop_only, push_pop;

  assign spcw      = bus.destspc ? bus.l : {5'b0, bus.wpc};
  assign push_only = bus.state_fetch & bus.spcpush & ~bus.spcpop;
  assign pop_only  = bus.state_fetch & ~bus.spcpush & bus.spcpop;
  assign push_pop  = bus.state_fetch & bus.spcpush & bus.spcpop;

`ifdef SPC_GUARD_EN
  logic [5:0] depth_q, depth_d;
  logic       spco_q, spco_d, spcu_q, spcu_d;
  logic       ovf_set, unf_set;
  logic       full, empty;

  assign full  = (depth_q == 6'd32);
  assign empty = (depth_q == 6'd0);

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push_only || (push_pop && empty)) begin
      // Push+pop on an empty stack has no top to replace, so it acts as a push.
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        ptr_d   = ptr_q + 5'd1;
        wr_en   = 1'b1;
        wr_idx  = ptr_q + 5'd1;
        depth_d = depth_q + 6'd1;
      end
    end else if (pop_only) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        ptr_d   = ptr_q - 5'd1;
        depth_d = depth_q - 6'd1;
      end
    end else if (push_pop) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end
  end

  // Set beats clear so an error in the clearing cycle is not lost.
  always_comb begin
    spco_d = ovf_set | (spco_q & ~bus.spc_clr_err);
    spcu_d = unf_set | (spcu_q & ~bus.spc_clr_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= 6'd0;
      spco_q  <= 1'b0;
      spcu_q  <= 1'b0;
    end else begin
      depth_q <= depth_d;
      spco_q  <= spco_d;
      spcu_q  <= spcu_d;
    end
  end

  assign bus.spco = spco_q;
  assign bus.spcu = spcu_q;
`else
  logic unused_clr_err;

  always_comb begin
    ptr_d  = ptr_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_only) begin
      ptr_d  = ptr_q + 5'd1;
      wr_en  = 1'b1;
      wr_idx = ptr_q + 5'd1;
    end else if (pop_only) begin
      ptr_d = ptr_q - 5'd1;
    end else if (push_pop) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end
  end

  assign unused_clr_err = bus.spc_clr_err;
  assign bus.spco       = 1'b0;
  assign bus.spcu       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= spcw;
    end
  end

  assign bus.spc    = mem_q[ptr_q];
  assign bus.spcptr = ptr_q;
endmodule

// File: tb/tb_spc_stack.sv
// Directed bench for spc_stack; expectations follow SPC_GUARD_EN when it is defined.
module tb_spc_stack;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  spc_stack_if bus ();

  spc_stack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.state_fetch = 1'b0;
    bus.spcpush     = 1'b0;
    bus.spcpop      = 1'b0;
    bus.destspc     = 1'b0;
    bus.wpc         = 14'h0;
    bus.l           = 19'h0;
    bus.spc_clr_err = 1'b0;
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic sf, input logic push, input logic pop, input logic dest,
                     input logic [13:0] w, input logic [18:0] ld, input logic clr);
    bus.state_fetch = sf;
    bus.spcpush     = push;
    bus.spcpop      = pop;
    bus.destspc     = dest;
    bus.wpc         = w;
    bus.l           = ld;
    bus.spc_clr_err = clr;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    reset = 1'b0;
    #1;
    check("rst_ptr", 32'(bus.spcptr), 32'h0);
    check("rst_spc", 32'(bus.spc), 32'h0);
    check("rst_spco", 32'(bus.spco), 32'h0);
    check("rst_spcu", 32'(bus.spcu), 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b1;

    // Push wpc
    cyc(1, 1, 0, 0, 14'h1234, 19'h0, 0);
    check("push_wpc_ptr", 32'(bus.spcptr), 32'h1);
    check("push_wpc_spc", 32'(bus.spc), 32'h01234);

    // Push L then pop from a fresh stack
    do_reset();
    cyc(1, 1, 0, 1, 14'h0, 19'h7ABCD, 0);
    check("push_l_ptr", 32'(bus.spcptr), 32'h1);
    check("push_l_spc", 32'(bus.spc), 32'h7ABCD);
    cyc(1, 0, 1, 0, 14'h0, 19'h0, 0);
    check("pop_ptr", 32'(bus.spcptr), 32'h0);
    check("pop_spc", 32'(bus.spc), 32'h0);

    // Replace top at pointer 3
    do_reset();
    cyc(1, 1, 0, 0, 14'h0011, 19'h0, 0);
    cyc(1, 1, 0, 0, 14'h0022, 19'h0, 0);
    cyc(1, 1, 0, 0, 14'h0033, 19'h0, 0);
    check("pre_rep_ptr", 32'(bus.spcptr), 32'h3);
    cyc(1, 1, 1, 0, 14'h0042, 19'h0, 0);
    check("rep_ptr", 32'(bus.spcptr), 32'h3);
    check("rep_spc", 32'(bus.spc), 32'h00042);
    cyc(1, 0, 1, 0, 14'h0, 19'h0, 0);
    check("rep_pop_ptr", 32'(bus.spcptr), 32'h2);
    check("rep_pop_spc", 32'(bus.spc), 32'h00022);

    // No update outside the fetch state
    cyc(0, 1, 0, 1, 14'h0, 19'h55555, 0);
    check("nofetch_ptr", 32'(bus.spcptr), 32'h2);
    check("nofetch_spc", 32'(bus.spc), 32'h00022);
    cyc(0, 0, 1, 0, 14'h0, 19'h0, 0);
    check("nofetch_pop_ptr", 32'(bus.spcptr), 32'h2);

    // Pop on an empty stack
    do_reset();
    cyc(1, 0, 1, 0, 14'h0, 19'h0, 0);
`ifdef SPC_GUARD_EN
    check("unf_ptr", 32'(bus.spcptr), 32'h0);
    check("unf_flag", 32'(bus.spcu), 32'h1);
    cyc(1, 0, 1, 0, 14'h0, 19'h0, 1);
    check("unf_set_wins", 32'(bus.spcu), 32'h1);
    cyc(0, 0, 0, 0, 14'h0, 19'h0, 1);
    check("unf_clr", 32'(bus.spcu), 32'h0);
`else
    check("wrap_pop_ptr", 32'(bus.spcptr), 32'h1F);
    check("wrap_pop_spcu", 32'(bus.spcu), 32'h0);
`endif
    check("empty_pop_spc", 32'(bus.spc), 32'h0);

    // Push+pop on an empty stack
    do_reset();
    cyc(1, 1, 1, 0, 14'h0055, 19'h0, 0);
`ifdef SPC_GUARD_EN
    check("pp_empty_ptr", 32'(bus.spcptr), 32'h1);
`else
    check("pp_empty_ptr", 32'(bus.spcptr), 32'h0);
`endif
    check("pp_empty_spc", 32'(bus.spc), 32'h00055);
    check("pp_empty_spcu", 32'(bus.spcu), 32'h0);

    // Fill all 32 entries, then one more push
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cyc(1, 1, 0, 0, 14'(i + 1), 19'h0, 0);
    end
    check("full_ptr", 32'(bus.spcptr), 32'h0);
    check("full_spc", 32'(bus.spc), 32'h00020);
    check("full_spco", 32'(bus.spco), 32'h0);
    cyc(1, 1, 0, 0, 14'h3FFF, 19'h0, 0);
`ifdef SPC_GUARD_EN
    check("ovf_ptr", 32'(bus.spcptr), 32'h0);
    check("ovf_spc", 32'(bus.spc), 32'h00020);
    check("ovf_flag", 32'(bus.spco), 32'h1);
    cyc(1, 1, 1, 0, 14'h0777, 19'h0, 0);
    check("pp_full_ptr", 32'(bus.spcptr), 32'h0);
    check("pp_full_spc", 32'(bus.spc), 32'h00777);
    cyc(0, 0, 0, 0, 14'h0, 19'h0, 1);
    check("ovf_clr", 32'(bus.spco), 32'h0);
`else
    check("wrap_push_ptr", 32'(bus.spcptr), 32'h1);
    check("wrap_push_spc", 32'(bus.spc), 32'h03FFF);
    check("wrap_push_spco", 32'(bus.spco), 32'h0);
`endif

    // Asynchronous reset with a push in flight
    do_reset();
    cyc(1, 1, 0, 0, 14'h0AAA, 19'h0, 0);
    cyc(1, 1, 0, 0, 14'h0BBB, 19'h0, 0);
    bus.state_fetch = 1'b1;
    bus.spcpush     = 1'b1;
    bus.wpc         = 14'h0CCC;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ptr", 32'(bus.spcptr), 32'h0);
    check("async_rst_spc", 32'(bus.spc), 32'h0);
    idle();
    @(posedge clk);
    #3;
    reset = 1'b1;
    cyc(1, 0, 0, 0, 14'h0, 19'h0, 0);
    check("post_rst_ptr", 32'(bus.spcptr), 32'h0);
    check("post_rst_spc", 32'(bus.spc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
